// File: rtl/count_report_ctrl.sv
// Command controller: forwards '@'/'h' to the counter datapath and reports the
// count as three ASCII digits plus CR/LF over the UART transmitter.
module count_report_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ctr_din,
    output logic       ctr_en,
    input  logic [7:0] ctr_cnt,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, FWD, SETTLE, CONV, SEND, GAP, DRAIN} state_t;

    localparam logic [7:0] CMD_CLR = 8'h40;
    localparam logic [7:0] CMD_INC = 8'h68;
    localparam logic [7:0] CMD_QRY = 8'h3F;

    state_t     state, state_nxt;
    logic [7:0] cmd, cmd_nxt;
    logic [7:0] rem, rem_nxt;
    logic [3:0] hund, hund_nxt;
    logic [3:0] tens, tens_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] pend_byte, pend_nxt;
    logic       pend_full, pend_full_nxt;
    logic       overrun_nxt;
    logic [7:0] ctr_din_nxt;
    logic [7:0] tx_data_nxt;
    logic       tx_start_nxt;
    logic       take;
    logic [7:0] in_byte;
    logic [7:0] send_byte;

    assign ctr_en = (state == FWD);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= 8'h00;
            rem       <= 8'h00;
            hund      <= 4'd0;
            tens      <= 4'd0;
            idx       <= 3'd0;
            pend_byte <= 8'h00;
            pend_full <= 1'b0;
            overrun   <= 1'b0;
            ctr_din   <= 8'h00;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd       <= cmd_nxt;
            rem       <= rem_nxt;
            hund      <= hund_nxt;
            tens      <= tens_nxt;
            idx       <= idx_nxt;
            pend_byte <= pend_nxt;
            pend_full <= pend_full_nxt;
            overrun   <= overrun_nxt;
            ctr_din   <= ctr_din_nxt;
            tx_data   <= tx_data_nxt;
            tx_start  <= tx_start_nxt;
        end
    end

    always_comb begin
        case (idx)
            3'd0:    send_byte = {4'h3, hund};
            3'd1:    send_byte = {4'h3, tens};
            3'd2:    send_byte = {4'h3, rem[3:0]};
            3'd3:    send_byte = 8'h0D;
            default: send_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd;
        rem_nxt       = rem;
        hund_nxt      = hund;
        tens_nxt      = tens;
        idx_nxt       = idx;
        pend_nxt      = pend_byte;
        pend_full_nxt = pend_full;
        overrun_nxt   = overrun;
        ctr_din_nxt   = ctr_din;
        tx_data_nxt   = tx_data;
        tx_start_nxt  = 1'b0;
        // A stored byte always wins over a fresh strobe in IDLE
        take          = pend_full | rx_valid;
        in_byte       = pend_full ? pend_byte : rx_data;

        case (state)
            IDLE: begin
                if (take) begin
                    if (in_byte == CMD_CLR || in_byte == CMD_INC) begin
                        cmd_nxt     = in_byte;
                        ctr_din_nxt = in_byte;
                        state_nxt   = FWD;
                    end else if (in_byte == CMD_QRY) begin
                        rem_nxt   = ctr_cnt;
                        hund_nxt  = 4'd0;
                        tens_nxt  = 4'd0;
                        state_nxt = CONV;
                    end
                end
            end
            FWD: begin
                if (cmd == CMD_INC) begin
                    state_nxt = SETTLE;
                end else begin
                    overrun_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            SETTLE: begin
                rem_nxt   = ctr_cnt;
                hund_nxt  = 4'd0;
                tens_nxt  = 4'd0;
                state_nxt = CONV;
            end
            CONV: begin
                if (rem >= 8'd100) begin
                    rem_nxt  = rem - 8'd100;
                    hund_nxt = hund + 4'd1;
                end else if (rem >= 8'd10) begin
                    rem_nxt  = rem - 8'd10;
                    tens_nxt = tens + 4'd1;
                end else begin
                    idx_nxt   = 3'd0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = send_byte;
                    state_nxt    = GAP;
                end
            end
            GAP: begin
                if (idx == 3'd4) begin
                    state_nxt = DRAIN;
                end else begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = SEND;
                end
            end
            DRAIN: begin
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Pending buffer; a drop sets overrun after any clear above
        if (state == IDLE) begin
            if (pend_full) begin
                pend_full_nxt = rx_valid;
                if (rx_valid) pend_nxt = rx_data;
            end
        end else if (rx_valid) begin
            if (!pend_full) begin
                pend_full_nxt = 1'b1;
                pend_nxt      = rx_data;
            end else begin
                overrun_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_report_ctrl.sv
// Directed bench for count_report_ctrl with a behavioural counter, a UART
// transmitter busy model and expected-byte scoreboards.
module tb_count_report_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] ctr_din;
    logic       ctr_en;
    logic [7:0] ctr_cnt;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       overrun;

    count_report_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .ctr_din(ctr_din), .ctr_en(ctr_en), .ctr_cnt(ctr_cnt),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Counter datapath model: 'h' increments (wrapping), '@' clears
    logic       load_en = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] cnt = 8'h00;
    assign ctr_cnt = cnt;
    always @(posedge clk) begin
        if (load_en) cnt <= load_val;
        else if (ctr_en && ctr_din == 8'h68) cnt <= cnt + 8'd1;
        else if (ctr_en && ctr_din == 8'h40) cnt <= 8'h00;
    end

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_start
    int busy_len = 10;
    int bcnt = 0;
    assign tx_busy = (bcnt != 0);
    always @(posedge clk) begin
        if (tx_start) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end

    logic [7:0] exp_tx[$];
    logic [7:0] obs_tx[$];
    logic [7:0] exp_ctr[$];
    logic [7:0] obs_ctr[$];
    int viol = 0;

    always @(negedge clk) begin
        if (tx_start) begin
            obs_tx.push_back(tx_data);
            if (tx_busy) viol++;
        end
        if (ctr_en) obs_ctr.push_back(ctr_din);
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic push_report(input int v);
        exp_tx.push_back(8'(8'h30 + v / 100));
        exp_tx.push_back(8'(8'h30 + (v / 10) % 10));
        exp_tx.push_back(8'(8'h30 + v % 10));
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
    endtask

    // Waits for three consecutive quiet cycles so a queued command is not missed
    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            if (!busy && !tx_busy) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle_timeout"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic score(input string tag);
        chk({tag, "_tx_count"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
        while (obs_tx.size() > 0 && exp_tx.size() > 0)
            chk({tag, "_tx_byte"}, 32'(obs_tx.pop_front()), 32'(exp_tx.pop_front()));
        chk({tag, "_ctr_count"}, 32'(obs_ctr.size()), 32'(exp_ctr.size()));
        while (obs_ctr.size() > 0 && exp_ctr.size() > 0)
            chk({tag, "_ctr_din"}, 32'(obs_ctr.pop_front()), 32'(exp_ctr.pop_front()));
        obs_tx.delete(); exp_tx.delete(); obs_ctr.delete(); exp_ctr.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctr_en"}, 32'(ctr_en), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_ctr_din"}, 32'(ctr_din), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Report after increment: 41 -> 42
        load(8'd41);
        exp_ctr.push_back(8'h68);
        push_report(42);
        send(8'h68);
        wait_idle("inc");
        score("inc");

        // Clear: busy high one cycle after strobe, low the next
        exp_ctr.push_back(8'h40);
        @(negedge clk);
        rx_data = 8'h40; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("clr_busy_fwd", 32'(busy), 32'd1);
        chk("clr_ctr_en", 32'(ctr_en), 32'd1);
        @(negedge clk);
        chk("clr_busy_done", 32'(busy), 32'd0);
        chk("clr_cnt", 32'(cnt), 32'd0);
        wait_idle("clr");
        score("clr");

        // Query at 255
        load(8'd255);
        push_report(255);
        send(8'h3F);
        wait_idle("qry");
        score("qry");

        // Unknown byte: no activity
        send(8'h78);
        chk("other_busy", 32'(busy), 32'd0);
        wait_idle("other");
        score("other");

        // Back-pressure with leading zeros
        busy_len = 200;
        viol = 0;
        load(8'd7);
        push_report(7);
        send(8'h3F);
        wait_idle("bp");
        chk("bp_start_while_busy", 32'(viol), 32'd0);
        score("bp");
        busy_len = 10;

        // Wrap 255 -> 0 reports "000"
        load(8'd255);
        exp_ctr.push_back(8'h68);
        push_report(0);
        send(8'h68);
        wait_idle("wrap");
        score("wrap");

        // Buffering and overrun
        load(8'd41);
        exp_ctr.push_back(8'h68);
        push_report(42);
        push_report(42);
        send(8'h68);
        repeat (2) @(negedge clk);
        send(8'h3F);
        send(8'h78);
        chk("buf_overrun_set", 32'(overrun), 32'd1);
        wait_idle("buf");
        chk("buf_overrun_held", 32'(overrun), 32'd1);
        score("buf");
        exp_ctr.push_back(8'h40);
        send(8'h40);
        wait_idle("buf_clr");
        chk("buf_overrun_cleared", 32'(overrun), 32'd0);
        score("buf_clr");

        // Reset during the third byte
        load(8'd41);
        exp_ctr.push_back(8'h68);
        exp_tx.push_back(8'h30);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h32);
        send(8'h68);
        n = 0;
        while (obs_tx.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_third_byte_seen", 32'(obs_tx.size() >= 3), 32'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_mid");
        @(negedge clk);
        chk("rst_mid_ctr_en", 32'(ctr_en), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("rst_no_tx_after", 32'(busy), 32'd0);
        score("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
